serial_lsb_comparator: RTL and testbench
========================================

Name: serial_lsb_comparator

Overview:
- Sequential magnitude comparator. Consumes two unsigned operands as a stream of 2-bit digit pairs, least-significant digit first.
- The combinational comparator slices cascade MSB-first; this block scans the opposite direction. A later, differing digit always overrides the running verdict.
- Sits behind serial/streaming datapaths where full-width operands are never available in parallel. Produces EQ/LT/GT plus a one-cycle done pulse.

Parameters:
- NDIGITS, 4, number of 2-bit digits per operand (operand width = 2*NDIGITS bits); legal range 1..64.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new comparison; sampled only in IDLE or DONE
- dig_valid  in  1  A/B carry a valid digit pair
- dig_ready  out  1  block accepts a digit this cycle
- A  in  2  digit of operand A
- B  in  2  digit of operand B
- busy  out  1  comparison in progress
- done  out  1  one-cycle pulse: result valid
- EQ  out  1  A == B (held)
- LT  out  1  A < B (held)
- GT  out  1  A > B (held)

Behaviour:
- Reset (async, immediate, any state): state=IDLE, digit counter=0, running eq=1, running lt=0. All outputs 0: dig_ready, busy, done, EQ, LT, GT.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - dig_ready=0, busy=0; EQ/LT/GT hold the last result.
  - start=1 -> RUN next edge; on that edge: counter=0, running eq=1, running lt=0, EQ/LT/GT cleared to 0.
  - dig_valid ignored; a digit presented in the same cycle as start is NOT consumed.
- RUN:
  - busy=1, dig_ready=1.
  - A digit is accepted on an edge where dig_valid=1. No acceptance when dig_valid=0; stalls of any length are allowed and the state is unchanged.
  - Update on acceptance:
    - A != B: running eq=0, running lt=(A<B), unsigned 2-bit comparison.
    - A == B: running eq/lt unchanged.
    - counter += 1.
  - start ignored in RUN (no restart).
  - Acceptance of digit NDIGITS-1 (counter == NDIGITS-1):
    - EQ/LT/GT are registered on the same edge, using the update that includes this final digit.
    - EQ = final eq; LT = final lt & ~final eq; GT = ~final eq & ~final lt.
    - State -> DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, dig_ready=0; EQ/LT/GT valid.
  - Next edge -> IDLE, unless start=1 -> RUN, with the same clearing as from IDLE.
- Invariants:
  - After any completed comparison, exactly one of EQ/LT/GT is 1.
  - Between start acceptance and completion, all three are 0.
  - done is never high for two consecutive cycles.
- Latency: done asserts the cycle after the NDIGITS-th accepted digit. Minimum start-to-done is NDIGITS+1 cycles with dig_valid held high.
- NDIGITS=1: the first accepted digit completes the comparison.
- Counter width is clog2(NDIGITS) bits with a minimum of 1; it must not wrap before the terminal compare.
- Reset mid-RUN abandons the comparison; no done pulse is produced.

Test Plan:
All cases use NDIGITS=4 (8-bit operands) and stream digits LSB first.
- Equal: start, A=0x5A, B=0x5A streamed back-to-back -> done one cycle after the 4th digit, EQ=1 LT=0 GT=0; busy high for exactly 4 cycles.
- Low-digit decides: A=0x12, B=0x13 (digit0 A=2, B=3; higher digits equal) -> LT=1, EQ=0, GT=0.
- High digit overrides low: A=0x81, B=0x7F (digit0 A<B, digit3 A=2 > B=1) -> GT=1, LT=0, EQ=0.
- Stalls and ignored inputs:
  - A=0x40, B=0x80 with dig_valid toggling 1,0,0,1,1,0,1 -> exactly 4 acceptances, LT=1.
  - start pulsed mid-RUN -> no restart, same result.
  - dig_valid high in IDLE -> no state change.
- Reset mid-operation: assert rst after 2 accepted digits -> all outputs 0 within the same cycle; no done pulse; a fresh start then compares 0xFF vs 0xFF -> EQ=1.
- Back-to-back: start held high during DONE -> immediate RUN with EQ/LT/GT cleared; second pair A=0x00, B=0x01 -> LT=1, done pulses once per comparison.

Source files
------------

// File: rtl/serial_lsb_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_lsb_comparator
// Description : Serial magnitude comparator fed 2-bit digit pairs LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_lsb_comparator #(
    parameter int NDIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dig_valid,
    output logic       dig_ready,
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       busy,
    output logic       done,
    output logic       EQ,
    output logic       LT,
    output logic       GT
);

    localparam int            CNT_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               res_eq_q, res_eq_d;
    logic               res_lt_q, res_lt_d;
    logic               res_gt_q, res_gt_d;
    logic               eq_upd, lt_upd;

    // Scanning upward, any differing digit outranks everything seen so far.
    always_comb begin
        eq_upd = eq_q;
        lt_upd = lt_q;
        if (A != B) begin
            eq_upd = 1'b0;
            lt_upd = (A < B);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        res_eq_d = res_eq_q;
        res_lt_d = res_lt_q;
        res_gt_d = res_gt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    eq_d     = 1'b1;
                    lt_d     = 1'b0;
                    res_eq_d = 1'b0;
                    res_lt_d = 1'b0;
                    res_gt_d = 1'b0;
                end
            end
            S_RUN: begin
                if (dig_valid) begin
                    eq_d  = eq_upd;
                    lt_d  = lt_upd;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_DIG) begin
                        state_d  = S_DONE;
                        res_eq_d = eq_upd;
                        res_lt_d = lt_upd & ~eq_upd;
                        res_gt_d = ~eq_upd & ~lt_upd;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            eq_q     <= 1'b1;
            lt_q     <= 1'b0;
            res_eq_q <= 1'b0;
            res_lt_q <= 1'b0;
            res_gt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            res_eq_q <= res_eq_d;
            res_lt_q <= res_lt_d;
            res_gt_q <= res_gt_d;
        end
    end

    assign dig_ready = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign EQ        = res_eq_q;
    assign LT        = res_lt_q;
    assign GT        = res_gt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_lsb_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_lsb_comparator
// Description : Self-checking bench; integer-compare reference, random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_lsb_comparator;

    localparam int ND = 4;
    localparam int W  = 2 * ND;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dig_valid;
    logic [1:0] A;
    logic [1:0] B;
    logic       dig_ready, busy, done, EQ, LT, GT;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] last_res = 3'b000;

    always #5 clk = ~clk;

    serial_lsb_comparator #(.NDIGITS(ND)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .EQ        (EQ),
        .LT        (LT),
        .GT        (GT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: dig_valid always high; 1: random; 2: fixed pattern (MSB first) then high.
    task automatic compare(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                           input logic [6:0] pat, input bit mid_start);
        int   acc      = 0;
        int   cyc      = 0;
        int   busy_cnt = 0;
        logic v;
        start     = 1'b1;
        dig_valid = 1'(($urandom_range(0, 1)));
        A         = 2'($urandom);
        B         = 2'($urandom);
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_clear", {EQ, LT, GT}, 3'b000);
        while (acc < ND && cyc < 200) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 2) v = (cyc < 7) ? pat[6 - cyc] : 1'b1;
            else                v = 1'(($urandom_range(0, 1)));
            dig_valid = v;
            A         = a[2*acc +: 2];
            B         = b[2*acc +: 2];
            start     = mid_start && (cyc == 2);
            if (cyc < 8) check("run_ready", dig_ready, 1);
            if (busy) busy_cnt++;
            step();
            if (v) acc++;
            cyc++;
        end
        start     = 1'b0;
        dig_valid = 1'b0;
        if (acc < ND) check("timeout", 0, 1);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", dig_ready, 0);
        last_res = {a == b, a < b, a > b};
        check("result", {EQ, LT, GT}, last_res);
        if (mode == 0) check("busy_cycles", busy_cnt, ND);
    endtask

    task automatic idle_step();
        step();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_hold", {EQ, LT, GT}, last_res);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst       = 1'b1;
        start     = 1'b0;
        dig_valid = 1'b0;
        A         = 2'd0;
        B         = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {dig_ready, busy, done, EQ, LT, GT}, 6'b0);
        rst = 1'b0;

        // dig_valid in IDLE must not start anything
        dig_valid = 1'b1;
        A = 2'd3;
        B = 2'd1;
        repeat (3) begin
            step();
            check("idle_valid", {dig_ready, busy, done}, 3'b000);
        end
        dig_valid = 1'b0;

        compare(8'h5A, 8'h5A, 0, 7'b0, 1'b0);
        idle_step();
        compare(8'h12, 8'h13, 0, 7'b0, 1'b0);
        idle_step();
        compare(8'h81, 8'h7F, 0, 7'b0, 1'b0);
        idle_step();
        compare(8'h40, 8'h80, 2, 7'b1001101, 1'b1);
        idle_step();

        // Reset after two accepted digits
        start = 1'b1;
        step();
        start     = 1'b0;
        dig_valid = 1'b1;
        A = 2'd1;
        B = 2'd2;
        step();
        step();
        dig_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {dig_ready, busy, done, EQ, LT, GT}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        last_res = 3'b000;
        repeat (4) idle_step();
        compare(8'hFF, 8'hFF, 0, 7'b0, 1'b0);

        // Back-to-back: start held during DONE
        compare(8'h00, 8'h01, 0, 7'b0, 1'b0);
        idle_step();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = {ra[W-1:2], 2'($urandom)};
                2:       rb = {2'($urandom), ra[W-3:0]};
                default: rb = W'($urandom);
            endcase
            compare(ra, rb, 1, 7'b0, 1'(($urandom_range(0, 1))));
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
